seq_mag_compare: RTL and testbench
==================================

# seq_mag_compare

Parametrised, digit-serial magnitude comparator that compares two WIDTH-bit unsigned operands DIGIT bits per clock, most-significant digit first, with an optional early exit on the first differing digit. It generalises the team's combinational 3-bit cascade comparators:

- It keeps the l/e/g cascade inputs, so a less-significant stage can still be chained below it.
- It adds a start/busy/done handshake and registered, held results.

It sits in datapaths where comparison width exceeds what fits in one cycle, or where area matters more than latency.

## Interface
- WIDTH, 8: operand width in bits, ≥ 1.
- DIGIT, 3: bits compared per cycle, 1..WIDTH.
- EARLY_EXIT, 1: when 1, scanning stops at the first differing digit; when 0, all digits are always scanned.
- Derived, not ports: N = ceil(WIDTH/DIGIT) digits. The operands are zero-extended at the top to N*DIGIT bits, so the top digit is padded with zeros.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; sampled only while ready=1.
- a  in  WIDTH  operand A, unsigned; captured on an accepted start.
- b  in  WIDTH  operand B, unsigned; captured on an accepted start.
- l_in  in  1  cascade "less" from a less-significant stage; captured on start.
- e_in  in  1  cascade "equal"; captured on start.
- g_in  in  1  cascade "greater"; captured on start.
- ready  out  1  high in IDLE.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- lt  out  1  registered result: A < B.
- eq  out  1  registered result: A = B.
- gt  out  1  registered result: A > B.

## Operation
States: IDLE, SCAN, DONE.

IDLE (ready=1):
- If start=1, capture a, b, l_in, e_in, g_in into internal registers.
- Load digit index idx = N-1 and go to SCAN.

SCAN (busy=1): each cycle compares captured digit idx of A with digit idx of B, as unsigned DIGIT-bit values.
- Digits differ and no difference recorded yet: record the result (A digit > B digit → gt, otherwise lt).
  - EARLY_EXIT=1: go to DONE.
  - EARLY_EXIT=0: keep scanning. Later digits never overwrite the recorded result.
- idx = 0 and no difference recorded at any digit: result = captured {l_in, e_in, g_in}, passed through verbatim. Non-one-hot cascade values are not corrected.
- idx = 0: go to DONE. Otherwise decrement idx.

DONE:
- done=1 for exactly one cycle.
- lt/eq/gt are updated on the same clock edge that enters DONE.
- Next state is unconditionally IDLE.

Result hold and other rules:
- lt/eq/gt hold their value until the next DONE or rst; they do not change during a subsequent SCAN.
- start while busy=1 or done=1 is ignored; no queueing.
- When DIGIT divides WIDTH, there are no pad bits. When WIDTH ≤ DIGIT, N = 1.
- idx register width = max(1, ceil(log2 N)).

## Timing
Reset (rst=1 at an edge, regardless of state):
- Next cycle: state=IDLE, ready=1, busy=0, done=0, lt=0, eq=0, gt=0.
- Captured registers are cleared to 0.
- Reset mid-SCAN aborts the scan; no done is produced.
- rst and start in the same cycle: rst wins and start is dropped.

Latency, with start accepted at edge T:
- SCAN occupies cycles T+1 … T+k, where k is the number of digits scanned.
- done is high in cycle T+k+1; ready returns in cycle T+k+2.
- EARLY_EXIT=0: k = N always, giving constant latency N+1.
- EARLY_EXIT=1: k = N-i when the first difference is at digit i, and k = N when all digits are equal.

Throughput: back-to-back starts are possible every k+2 cycles; start is first sampled again in the cycle ready=1.

Operand inputs may change freely after the accepting edge; only the captured copies are used.

## Test plan
All cases use WIDTH=8, DIGIT=3 (N=3, top digit = {0, A[7:6]}) unless noted.

1. a=0xA5, b=0xA5, {l,e,g}={0,1,0}, start at T → done at T+4; eq=1, lt=0, gt=0.
2. a=0xC0, b=0x40, EARLY_EXIT=1 → top digit 3 vs 1; done at T+2; gt=1. Same stimulus with EARLY_EXIT=0 → done at T+4; gt=1.
3. a=0x2A, b=0x2C → digits 0=0, 5=5, 2<4; done at T+4; lt=1, eq=0, gt=0.
4. a=b=0x3F, cascade {l,e,g}={1,0,0} → lt=1. Repeat with {0,0,1} → gt=1.
5. Start accepted, then rst=1 at T+2 → cycle T+3: ready=1, all outputs 0; done never pulses. A start pulsed during SCAN with no reset → ignored; the original operands' result is delivered.
6. WIDTH=16, DIGIT=4, EARLY_EXIT=1: a=0x1234, b=0x1235 → done at T+5, lt=1. Then immediately a=0xFFFF, b=0x0000 → done 2 cycles after the new start, gt=1. lt/eq/gt hold their previous values throughout the second SCAN.

Source files
------------

// File: rtl/seq_mag_compare.sv
// Digit-serial unsigned magnitude comparator, most-significant digit first,
// with l/e/g cascade inputs for chaining and a start/busy/done handshake.
module seq_mag_compare #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 3,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l_in,
  input  logic             e_in,
  input  logic             g_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int N     = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PAD_W = N * DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [PAD_W-1:0] a_q, b_q;
  logic [2:0]       cas_q;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             found_gt;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             diff_now;
  logic             finish_scan;
  logic [2:0]       scan_res;

  // NOTE: every variable driven from always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  assign diff_now    = !found && (a_dig != b_dig);
  assign finish_scan = (idx == '0) || (EARLY_EXIT && diff_now);

  // First recorded difference wins; cascade passes through untouched otherwise.
  always_comb begin
    scan_res = cas_q;
    if (diff_now) begin
      scan_res = (a_dig > b_dig) ? 3'b001 : 3'b100;
    end else if (found) begin
      scan_res = found_gt ? 3'b001 : 3'b100;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cas_q    <= '0;
      idx      <= '0;
      found    <= 1'b0;
      found_gt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= PAD_W'(a);
            b_q      <= PAD_W'(b);
            cas_q    <= {l_in, e_in, g_in};
            idx      <= IDX_TOP;
            found    <= 1'b0;
            found_gt <= 1'b0;
            state    <= SCAN;
            ready    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (diff_now) begin
            found    <= 1'b1;
            found_gt <= (a_dig > b_dig);
          end
          if (finish_scan) begin
            {lt, eq, gt} <= scan_res;
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Self-checking bench: three comparator configurations driven in lockstep and
// checked cycle by cycle against an arithmetic reference model.
module tb_seq_mag_compare;

  localparam int CFG_W  [3] = '{8, 8, 16};
  localparam int CFG_D  [3] = '{3, 3, 4};
  localparam int CFG_EE [3] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        l_in, e_in, g_in;
  logic [2:0]  ready, busy, done, lt, eq, gt;

  int errors = 0;
  int checks = 0;
  logic [2:0] prev [3];

  always #5 clk = ~clk;

  seq_mag_compare #(.WIDTH(8), .DIGIT(3), .EARLY_EXIT(1'b1)) u_ee8 (
    .clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]),
    .l_in(l_in), .e_in(e_in), .g_in(g_in),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]),
    .lt(lt[0]), .eq(eq[0]), .gt(gt[0]));

  seq_mag_compare #(.WIDTH(8), .DIGIT(3), .EARLY_EXIT(1'b0)) u_full8 (
    .clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]),
    .l_in(l_in), .e_in(e_in), .g_in(g_in),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]),
    .lt(lt[1]), .eq(eq[1]), .gt(gt[1]));

  seq_mag_compare #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) u_ee16 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .l_in(l_in), .e_in(e_in), .g_in(g_in),
    .ready(ready[2]), .busy(busy[2]), .done(done[2]),
    .lt(lt[2]), .eq(eq[2]), .gt(gt[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Result is plain magnitude order of the zero-extended operands; scan length
  // follows from the digit holding the most significant differing bit.
  function automatic void model(input int w, input int d, input int ee,
                                input logic [15:0] av, input logic [15:0] bv,
                                input logic [2:0] cas,
                                output logic [2:0] res, output int k);
    int n, x, y, msb;
    n   = (w + d - 1) / d;
    x   = int'(av) % (1 << w);
    y   = int'(bv) % (1 << w);
    res = cas;
    k   = n;
    if (x < y) res = 3'b100;
    else if (x > y) res = 3'b001;
    if (x != y && ee != 0) begin
      msb = 0;
      for (int i = 0; i < w; i++) if ((x ^ y) >= (1 << i)) msb = i;
      k = n - msb / d;
    end
  endfunction

  // One transaction on all three instances; handshake and results checked
  // every cycle, with results required to hold until done.
  task automatic run(input string name, input logic [15:0] av, input logic [15:0] bv,
                     input logic [2:0] cas, input logic [2:0] r0, input int k0,
                     input logic [2:0] r1, input int k1, input int pulse_at);
    logic [2:0] re [3];
    int ke [3];
    int kmax;
    re[0] = r0; ke[0] = k0;
    re[1] = r1; ke[1] = k1;
    model(CFG_W[2], CFG_D[2], CFG_EE[2], av, bv, cas, re[2], ke[2]);
    kmax = ke[0];
    for (int j = 1; j < 3; j++) if (ke[j] > kmax) kmax = ke[j];
    a = av; b = bv; {l_in, e_in, g_in} = cas; start = 1'b1;
    for (int c = 1; c <= kmax + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        {l_in, e_in, g_in} = 3'($urandom);
      end
      if (c == pulse_at) start = 1'b1;
      else if (c == pulse_at + 1) start = 1'b0;
      for (int j = 0; j < 3; j++) begin
        check($sformatf("%s u%0d c%0d handshake", name, j, c),
              {ready[j], busy[j], done[j]},
              (c <= ke[j]) ? 3'b010 : ((c == ke[j] + 1) ? 3'b001 : 3'b100));
        check($sformatf("%s u%0d c%0d result", name, j, c),
              {lt[j], eq[j], gt[j]}, (c <= ke[j]) ? prev[j] : re[j]);
      end
    end
    prev = re;
  endtask

  task automatic reset_mid;
    a = 16'h5555; b = 16'h5555; {l_in, e_in, g_in} = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) check($sformatf("rst_mid u%0d busy", j), busy[j], 1'b1);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int j = 0; j < 3; j++) prev[j] = 3'b000;
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("rst_mid u%0d c%0d handshake", j, c),
              {ready[j], busy[j], done[j]}, 3'b100);
        check($sformatf("rst_mid u%0d c%0d result", j, c), {lt[j], eq[j], gt[j]}, 3'b000);
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cas;
    logic [2:0]  res8;
    int          k_ee;
    int          k_full;
    int          pulse;
  } vec_t;

  initial begin
    vec_t vecs [12];
    logic [2:0] r0, r1, r2;
    logic [15:0] ra, rb;
    logic [2:0] rc;
    int k0, k1, k2;

    vecs[0]  = '{16'h00A5, 16'h00A5, 3'b010, 3'b010, 3, 3, 0};
    vecs[1]  = '{16'h00C0, 16'h0040, 3'b010, 3'b001, 1, 3, 0};
    vecs[2]  = '{16'h002A, 16'h002C, 3'b010, 3'b100, 3, 3, 0};
    vecs[3]  = '{16'h003F, 16'h003F, 3'b100, 3'b100, 3, 3, 0};
    vecs[4]  = '{16'h003F, 16'h003F, 3'b001, 3'b001, 3, 3, 0};
    vecs[5]  = '{16'h0000, 16'h00FF, 3'b000, 3'b100, 1, 3, 0};
    vecs[6]  = '{16'h0007, 16'h0006, 3'b010, 3'b001, 3, 3, 0};
    vecs[7]  = '{16'h0055, 16'h0055, 3'b111, 3'b111, 3, 3, 0};
    vecs[8]  = '{16'h0038, 16'h0000, 3'b010, 3'b001, 2, 3, 0};
    vecs[9]  = '{16'h1234, 16'h1235, 3'b010, 3'b100, 3, 3, 0};
    vecs[10] = '{16'hFFFF, 16'h0000, 3'b010, 3'b001, 1, 3, 0};
    vecs[11] = '{16'h5A5A, 16'h5A5A, 3'b010, 3'b010, 3, 3, 2};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; {l_in, e_in, g_in} = 3'b000;
    for (int j = 0; j < 3; j++) prev[j] = 3'b000;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset u%0d handshake", j), {ready[j], busy[j], done[j]}, 3'b100);
      check($sformatf("reset u%0d result", j), {lt[j], eq[j], gt[j]}, 3'b000);
    end
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      run($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].cas,
          vecs[v].res8, vecs[v].k_ee, vecs[v].res8, vecs[v].k_full, vecs[v].pulse);
    end

    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      rc = 3'($urandom);
      model(CFG_W[0], CFG_D[0], CFG_EE[0], ra, rb, rc, r0, k0);
      model(CFG_W[1], CFG_D[1], CFG_EE[1], ra, rb, rc, r1, k1);
      run($sformatf("rand%0d", t), ra, rb, rc, r0, k0, r1, k1, 0);
    end

    run("pre_rst", 16'h00C0, 16'h0040, 3'b010, 3'b001, 1, 3'b001, 3, 0);
    reset_mid();
    model(CFG_W[0], CFG_D[0], CFG_EE[0], 16'h0102, 16'h0201, 3'b010, r2, k2);
    run("post_rst", 16'h0102, 16'h0201, 3'b010, 3'b001, 3, 3'b001, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
